vga_scan_engine: RTL

VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_timing.sv | 67 ++++++
 rtl/vga_scan_engine.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, frame-size helpers and pipeline stage bundle
// for the VGA scan engine.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic win;
    } vga_stage_t;

    function automatic int h_total(input int act, input int fp,
                                   input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp,
                                   input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Fetch latency plus the pixel capture register.
    function automatic int stage_dly(input int rd_lat);
        return rd_lat + 1;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters with wrap flags and active-high
// sync decode for stage 0.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int HW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int VW = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          h_wrap,
    output logic          v_wrap,
    output logic          hs,
    output logic          vs
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic [31:0]   h32, v32;

    always_comb begin
        h32      = 32'(hcount_q);
        v32      = 32'(vcount_q);
        h_wrap   = (h32 == H_TOTAL - 1);
        v_wrap   = h_wrap && (v32 == V_TOTAL - 1);
        hs       = (h32 >= H_ACTIVE + H_FP) &&
                   (h32 <  H_ACTIVE + H_FP + H_SYNC);
        vs       = (v32 >= V_ACTIVE + V_FP) &&
                   (v32 <  V_ACTIVE + V_FP + V_SYNC);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (en) begin
            hcount_d = h_wrap ? '0 : hcount_q + HW'(1);
            if (h_wrap) begin
                vcount_d = v_wrap ? '0 : vcount_q + VW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount = hcount_q;
    assign vcount = vcount_q;

endmodule

// File: rtl/vga_scan_engine.sv
// VGA scan-out: framebuffer fetch, pixel replication and aligned syncs.
// Optional macro VGA_BORDER_EN fills clipped active pixels with BORDER_COLOR.
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SCALE_SH = 1,
    parameter int FB_W     = 320,
    parameter int FB_H     = 240,
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter bit SYNC_POL = 1'b0
`ifdef VGA_BORDER_EN
    ,
    parameter logic [DATA_W-1:0] BORDER_COLOR = '1
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [DATA_W-1:0] pixel,
    output logic              frame_start,
    output logic              line_start
);

    localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DLY      = stage_dly(RD_LAT);
    localparam int REP_MASK = (1 << SCALE_SH) - 1;
`ifdef VGA_BORDER_EN
    localparam logic [DATA_W-1:0] FILL = BORDER_COLOR;
`else
    localparam logic [DATA_W-1:0] FILL = '0;
`endif

    logic [HW-1:0]     hcount;
    logic [VW-1:0]     vcount;
    logic              h_wrap, v_wrap, hs0, vs0;
    logic [31:0]       h32, v32, col32, row32;
    logic              de0, win0;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] pixel_q, pixel_d;
    vga_stage_t        pipe_q [DLY];
    vga_stage_t        pipe_d [DLY];

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .hcount (hcount),
        .vcount (vcount),
        .h_wrap (h_wrap),
        .v_wrap (v_wrap),
        .hs     (hs0),
        .vs     (vs0)
    );

    always_comb begin
        h32    = 32'(hcount);
        v32    = 32'(vcount);
        col32  = h32 >> SCALE_SH;
        row32  = v32 >> SCALE_SH;
        de0    = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
        win0   = de0 && (col32 < FB_W) && (row32 < FB_H);
        base_d = base_q;
        // Base stops at the last stored row so the address never wraps.
        if (en) begin
            if (v_wrap) begin
                base_d = '0;
            end else if (h_wrap && ((v32 & REP_MASK) == REP_MASK) &&
                         (row32 + 1 < FB_H)) begin
                base_d = base_q + ADDR_W'(FB_W);
            end
        end
        pipe_d  = pipe_q;
        pixel_d = pixel_q;
        if (en) begin
            pipe_d[0].hs  = hs0;
            pipe_d[0].vs  = vs0;
            pipe_d[0].de  = de0;
            pipe_d[0].win = win0;
            for (int i = 1; i < DLY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
            // Stage RD_LAT-1 lines up with the returning read data.
            if (!pipe_q[RD_LAT-1].de) begin
                pixel_d = '0;
            end else if (pipe_q[RD_LAT-1].win) begin
                pixel_d = mem_data;
            end else begin
                pixel_d = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            pixel_q <= '0;
            for (int i = 0; i < DLY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            base_q  <= base_d;
            pixel_q <= pixel_d;
            pipe_q  <= pipe_d;
        end
    end

    assign mem_rd      = !rst && en && win0;
    assign mem_addr    = rst ? '0 : base_q + ADDR_W'(col32);
    assign frame_start = !rst && en && (h32 == 0) && (v32 == 0);
    assign line_start  = !rst && en && (h32 == 0);
    assign hsync       = pipe_q[DLY-1].hs ? SYNC_POL : ~SYNC_POL;
    assign vsync       = pipe_q[DLY-1].vs ? SYNC_POL : ~SYNC_POL;
    assign de          = pipe_q[DLY-1].de;
    assign pixel       = pixel_q;

endmodule
